pipe_hazard_ctrl: RTL and testbench

- Pipeline sequencing controller for the 5-stage WISC core.
- Drives the write-enables and bubble/flush controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB latches.
- Arbitrates among data-memory stalls, branch redirects, register RAW hazards and instruction-memory stalls.
- Keeps stall statistics and runs a data-memory watchdog.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 24 ++
 rtl/pipe_hazard_ctrl_raw_hazard_detect.sv | 39 +++
 rtl/pipe_hazard_ctrl.sv | 155 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the WISC pipeline sequencing controller.
// State codes, register address width and the NOP instruction encoding.
package pipe_hazard_ctrl_pkg;

   localparam int REG_ADDR_W = 3;

   localparam logic [15:0] NOP_INSTR = 16'h0800;

   typedef logic [1:0] state_t;

   localparam state_t RUN       = 2'd0;
   localparam state_t DMEM_WAIT = 2'd1;
   localparam state_t FLUSH     = 2'd2;

   // True when a source operand is actually read and names register dst.
   function automatic logic reg_match(
      input logic                  rd_en,
      input logic [REG_ADDR_W-1:0] src,
      input logic [REG_ADDR_W-1:0] dst
   );
      return rd_en & (src == dst);
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_raw_hazard_detect.sv
// Combinational RAW hazard comparator for the instruction in ID.
// PIPE_HAZARD_FWD_EN: forwarding present, only load-use hazards stall.
module raw_hazard_detect
   import pipe_hazard_ctrl_pkg::*;
(
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic                  id_reads_rs,
   input  logic                  id_reads_rt,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic                  ex_regwrite,
   input  logic                  ex_memtoreg,
   input  logic [REG_ADDR_W-1:0] mem_rd,
   input  logic                  mem_regwrite,
   output logic                  hazard
);

   logic ex_hit;
   logic mem_hit;

   assign ex_hit  = reg_match(id_reads_rs, id_rs, ex_rd)
                  | reg_match(id_reads_rt, id_rt, ex_rd);
   assign mem_hit = reg_match(id_reads_rs, id_rs, mem_rd)
                  | reg_match(id_reads_rt, id_rt, mem_rd);

`ifdef PIPE_HAZARD_FWD_EN
   // The forwarding network covers everything except a load in EX.
   logic unused_mem;
   assign unused_mem = mem_hit | mem_regwrite;
   assign hazard     = ex_regwrite & ex_memtoreg & ex_hit;
`else
   // No forwarding: any pending write in EX or MEM must land first.
   logic unused_ld;
   assign unused_ld = ex_memtoreg;
   assign hazard    = (ex_regwrite & ex_hit)
                    | (mem_regwrite & mem_hit);
`endif

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: latch enables, flush/bubble, stats.
// Optional forwarding-aware hazard check via PIPE_HAZARD_FWD_EN.
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int DMEM_TIMEOUT = 64,
   parameter int CNT_W        = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic                  id_reads_rs,
   input  logic                  id_reads_rt,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic                  ex_regwrite,
   input  logic                  ex_memtoreg,
   input  logic [REG_ADDR_W-1:0] mem_rd,
   input  logic                  mem_regwrite,
   input  logic                  branch_taken_ex,
   input  logic                  imem_stall,
   input  logic                  dmem_stall,
   input  logic                  dmem_done,
   output logic                  pc_en,
   output logic                  ifid_en,
   output logic                  ifid_flush,
   output logic                  idex_en,
   output logic                  idex_stall,
   output logic                  exmem_en,
   output logic                  memwb_en,
   output logic                  dmem_timeout_err,
   output logic [CNT_W-1:0]      stall_cycles,
   output logic [CNT_W-1:0]      bubble_count
);

   localparam int WAIT_W = $clog2(DMEM_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(DMEM_TIMEOUT - 1);

   state_t            state;
   state_t            state_n;
   logic [WAIT_W-1:0] wait_cnt;
   logic [WAIT_W-1:0] wait_n;
   logic              err_set;
   logic              raw;
   logic              freeze;
   logic              raw_live;

   raw_hazard_detect u_raw (
      .id_rs        (id_rs),
      .id_rt        (id_rt),
      .id_reads_rs  (id_reads_rs),
      .id_reads_rt  (id_reads_rt),
      .ex_rd        (ex_rd),
      .ex_regwrite  (ex_regwrite),
      .ex_memtoreg  (ex_memtoreg),
      .mem_rd       (mem_rd),
      .mem_regwrite (mem_regwrite),
      .hazard       (raw)
   );

   // In DMEM_WAIT the pipe stays frozen until done; elsewhere a new
   // busy data access freezes it. ID holds a NOP right after a flush.
   assign freeze   = (state == DMEM_WAIT) ? ~dmem_done
                                          : (dmem_stall & ~dmem_done);
   assign raw_live = raw & (state != FLUSH);

   // Prioritised latch controls; reset forces every stage to advance.
   always_comb begin
      pc_en      = 1'b1;
      ifid_en    = 1'b1;
      ifid_flush = 1'b0;
      idex_en    = 1'b1;
      idex_stall = 1'b0;
      exmem_en   = 1'b1;
      memwb_en   = 1'b1;
      if (rst) begin
         pc_en = 1'b1;
      end else if (freeze) begin
         pc_en    = 1'b0;
         ifid_en  = 1'b0;
         idex_en  = 1'b0;
         exmem_en = 1'b0;
         memwb_en = 1'b0;
      end else if (branch_taken_ex) begin
         ifid_flush = 1'b1;
         idex_stall = 1'b1;
      end else if (raw_live) begin
         pc_en      = 1'b0;
         ifid_en    = 1'b0;
         idex_stall = 1'b1;
      end else if (imem_stall) begin
         pc_en      = 1'b0;
         ifid_flush = 1'b1;
      end
   end

   // Next state, watchdog count and timeout detection.
   always_comb begin
      state_n = state;
      wait_n  = '0;
      err_set = 1'b0;
      unique case (state)
         RUN: begin
            if (freeze)
               state_n = DMEM_WAIT;
            else if (branch_taken_ex)
               state_n = FLUSH;
         end
         DMEM_WAIT: begin
            if (dmem_done) begin
               state_n = branch_taken_ex ? FLUSH : RUN;
            end else if (wait_cnt == WAIT_LAST) begin
               state_n = RUN;
               err_set = 1'b1;
            end else begin
               wait_n = wait_cnt + WAIT_W'(1);
            end
         end
         FLUSH: begin
            state_n = freeze ? DMEM_WAIT : RUN;
         end
         default: begin
            state_n = RUN;
         end
      endcase
   end

   // Sequencer state, wait counter and sticky watchdog flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= RUN;
         wait_cnt         <= '0;
         dmem_timeout_err <= 1'b0;
      end else begin
         state    <= state_n;
         wait_cnt <= wait_n;
         if (err_set)
            dmem_timeout_err <= 1'b1;
      end
   end

   // Saturating stall and bubble statistics.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cycles <= '0;
         bubble_count <= '0;
      end else begin
         if (!pc_en && stall_cycles != '1)
            stall_cycles <= stall_cycles + CNT_W'(1);
         if (idex_stall && idex_en && bubble_count != '1)
            bubble_count <= bubble_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl.
// Expected controls queued per cycle, popped when outputs are sampled.
module tb_pipe_hazard_ctrl;

   localparam int CW = 16;

   // {pc_en, ifid_en, ifid_flush, idex_en, idex_stall, exmem_en, memwb_en}
   localparam logic [6:0] RUNC = 7'b1101011;
   localparam logic [6:0] FRZC = 7'b0000000;
   localparam logic [6:0] BRC  = 7'b1111111;
   localparam logic [6:0] RAWC = 7'b0001111;
   localparam logic [6:0] IMC  = 7'b0111011;

`ifdef PIPE_HAZARD_FWD_EN
   localparam logic [6:0] NLDC = RUNC;
`else
   localparam logic [6:0] NLDC = RAWC;
`endif

   typedef struct packed {
      logic [6:0]    ctrl;
      logic          err;
      logic [CW-1:0] sc;
      logic [CW-1:0] bc;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   logic [2:0] id_rs, id_rt, ex_rd, mem_rd;
   logic id_reads_rs, id_reads_rt;
   logic ex_regwrite, ex_memtoreg, mem_regwrite;
   logic branch_taken_ex, imem_stall, dmem_stall, dmem_done;
   logic pc_en, ifid_en, ifid_flush, idex_en, idex_stall;
   logic exmem_en, memwb_en, dmem_timeout_err;
   logic [CW-1:0] stall_cycles, bubble_count;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc_no  = 0;
   logic [CW-1:0] m_sc;
   logic [CW-1:0] m_bc;
   exp_t sb[$];

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.DMEM_TIMEOUT(64), .CNT_W(CW)) dut (
      .clk              (clk),
      .rst              (rst),
      .id_rs            (id_rs),
      .id_rt            (id_rt),
      .id_reads_rs      (id_reads_rs),
      .id_reads_rt      (id_reads_rt),
      .ex_rd            (ex_rd),
      .ex_regwrite      (ex_regwrite),
      .ex_memtoreg      (ex_memtoreg),
      .mem_rd           (mem_rd),
      .mem_regwrite     (mem_regwrite),
      .branch_taken_ex  (branch_taken_ex),
      .imem_stall       (imem_stall),
      .dmem_stall       (dmem_stall),
      .dmem_done        (dmem_done),
      .pc_en            (pc_en),
      .ifid_en          (ifid_en),
      .ifid_flush       (ifid_flush),
      .idex_en          (idex_en),
      .idex_stall       (idex_stall),
      .exmem_en         (exmem_en),
      .memwb_en         (memwb_en),
      .dmem_timeout_err (dmem_timeout_err),
      .stall_cycles     (stall_cycles),
      .bubble_count     (bubble_count)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc_no, got, exp);
      end
   endtask

   task automatic clr();
      id_rs = '0; id_rt = '0; ex_rd = '0; mem_rd = '0;
      id_reads_rs = 0; id_reads_rt = 0;
      ex_regwrite = 0; ex_memtoreg = 0; mem_regwrite = 0;
      branch_taken_ex = 0; imem_stall = 0;
      dmem_stall = 0; dmem_done = 0;
   endtask

   // One cycle: queue expectation, sample, compare, advance past the edge.
   task automatic cyc(input logic [6:0] ctrl, input logic err);
      exp_t e;
      sb.push_back('{ctrl: ctrl, err: err, sc: m_sc, bc: m_bc});
      #1;
      e = sb.pop_front();
      check("ctrl", {25'd0, pc_en, ifid_en, ifid_flush, idex_en,
                     idex_stall, exmem_en, memwb_en}, {25'd0, e.ctrl});
      check("err", {31'd0, dmem_timeout_err}, {31'd0, e.err});
      check("stall_cycles", {16'd0, stall_cycles}, {16'd0, e.sc});
      check("bubble_count", {16'd0, bubble_count}, {16'd0, e.bc});
      if (rst) begin
         m_sc = '0;
         m_bc = '0;
      end else begin
         if (!ctrl[6]) m_sc = m_sc + 1'b1;
         if (ctrl[2] && ctrl[3]) m_bc = m_bc + 1'b1;
      end
      @(posedge clk);
      #1;
      cyc_no++;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout sim did not finish");
      $fatal(1, "time limit");
   end

   initial begin
      clr();
      m_sc = '0;
      m_bc = '0;
      rst = 1'b1;
      imem_stall = 1'b1;
      @(posedge clk);
      #1;
      // Reset forces all enables even with a stall request present.
      cyc(RUNC, 1'b0);
      cyc(RUNC, 1'b0);
      rst = 1'b0;
      clr();
      cyc(RUNC, 1'b0);
      cyc(RUNC, 1'b0);

      // Load-use on rs.
      ex_memtoreg = 1; ex_regwrite = 1; ex_rd = 3;
      id_reads_rs = 1; id_rs = 3;
      cyc(RAWC, 1'b0);
      clr();
      cyc(RUNC, 1'b0);

      // Producer in MEM, and non-load producer in EX.
      mem_regwrite = 1; mem_rd = 3; id_reads_rs = 1; id_rs = 3;
      cyc(NLDC, 1'b0);
      clr();
      ex_regwrite = 1; ex_rd = 5; id_reads_rt = 1; id_rt = 5;
      cyc(NLDC, 1'b0);
      // Matching field but not read, and read but no write.
      clr();
      ex_regwrite = 1; ex_memtoreg = 1; ex_rd = 5; id_rt = 5;
      cyc(RUNC, 1'b0);
      clr();
      ex_memtoreg = 1; ex_rd = 6; id_reads_rs = 1; id_rs = 6;
      cyc(RUNC, 1'b0);
      clr();

      // Branch with concurrent rt hazard, then FLUSH suppresses it.
      ex_regwrite = 1; ex_memtoreg = 1; ex_rd = 2;
      id_reads_rt = 1; id_rt = 2;
      branch_taken_ex = 1;
      cyc(BRC, 1'b0);
      branch_taken_ex = 0;
      cyc(RUNC, 1'b0);
      cyc(RAWC, 1'b0);
      clr();

      // Five frozen cycles, then the done cycle advances everything.
      dmem_stall = 1;
      for (int i = 0; i < 5; i++) cyc(FRZC, 1'b0);
      dmem_stall = 0; dmem_done = 1;
      cyc(RUNC, 1'b0);
      clr();
      cyc(RUNC, 1'b0);

      // Freeze beats a branch; branch acts in the done cycle.
      dmem_stall = 1; branch_taken_ex = 1;
      cyc(FRZC, 1'b0);
      cyc(FRZC, 1'b0);
      dmem_stall = 0; dmem_done = 1;
      cyc(BRC, 1'b0);
      clr();
      ex_regwrite = 1; ex_rd = 4; id_reads_rs = 1; id_rs = 4;
      cyc(RUNC, 1'b0);
      clr();

      // Instruction-memory stall for three cycles.
      imem_stall = 1;
      for (int i = 0; i < 3; i++) cyc(IMC, 1'b0);
      clr();
      cyc(RUNC, 1'b0);

      // Watchdog: one RUN cycle plus 64 DMEM_WAIT cycles, then flag.
      dmem_stall = 1;
      for (int i = 0; i < 65; i++) cyc(FRZC, 1'b0);
      dmem_stall = 0;
      // Back in RUN: without done the pipe advances.
      cyc(RUNC, 1'b1);
      cyc(RUNC, 1'b1);
      dmem_stall = 1;
      cyc(FRZC, 1'b1);
      cyc(FRZC, 1'b1);
      dmem_stall = 0;
      cyc(FRZC, 1'b1);
      dmem_done = 1;
      cyc(RUNC, 1'b1);
      clr();

      // Reset in the middle of DMEM_WAIT.
      dmem_stall = 1;
      cyc(FRZC, 1'b1);
      cyc(FRZC, 1'b1);
      dmem_stall = 0;
      rst = 1;
      cyc(RUNC, 1'b1);
      rst = 0;
      cyc(RUNC, 1'b0);
      cyc(RUNC, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
